genius_seq_ctrl: RTL and testbench

Game sequencer for the Genius (Simon) design. It owns an N-bit sequence store of 2-bit colour codes and appends one pseudo-random colour per round. It plays the sequence back on the four LEDs, then checks the player's debounced button presses against it. It reports the current level and a win or lose result to the display and top level.

---
 rtl/genius_seq_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_genius_seq_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/genius_seq_ctrl.sv
// Simon-style game sequencer: grows a random colour sequence one step per round,
// plays it on the LEDs and checks the player's presses against it.
module genius_seq_ctrl #(
    parameter int          N         = 64,
    parameter int          T_ON      = 4,
    parameter int          T_OFF     = 2,
    parameter int          T_TIMEOUT = 16,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic       CLK,
    input  logic       R,
    input  logic       tick,
    input  logic       start,
    input  logic [3:0] btn,
    output logic [3:0] led,
    output logic [5:0] level,
    output logic       busy,
    output logic       win,
    output logic       lose
);

    // state    | meaning
    // IDLE     | waiting for the first start after reset
    // ADD      | append one random colour, bump level (1 clock)
    // SHOW_ON  | LED for step idx lit for T_ON ticks
    // SHOW_OFF | dark gap after step idx for T_OFF ticks
    // WAIT_IN  | comparing player presses against step idx
    // WIN      | full MAX_LEN sequence reproduced
    // LOSE     | wrong press, multi-press or input timeout

    localparam int MAX_LEN = N / 2;
    localparam int T_MAX1  = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int T_MAX   = (T_MAX1 > T_TIMEOUT) ? T_MAX1 : T_TIMEOUT;
    localparam int TW      = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, LOSE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    led_q, led_d;
    logic [5:0]    level_q, level_d;
    logic          busy_q, busy_d;
    logic          win_q, win_d;
    logic          lose_q, lose_d;
    logic [N-1:0]  seq_q, seq_d;
    logic [5:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   lfsr_q, lfsr_d;

    function automatic logic [1:0] step_at(input logic [N-1:0] s, input logic [5:0] i);
        step_at = 2'b00;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (i == 6'(k)) step_at = s[2*k +: 2];
        end
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] c);
        onehot = 4'b0001 << c;
    endfunction

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        level_d = level_q;
        seq_d   = seq_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        case (state_q)
            IDLE: begin
                led_d = 4'b0000;
                if (start) begin
                    state_d = ADD;
                    level_d = 6'd0;
                end
            end
            ADD: begin
                for (int k = 0; k < MAX_LEN; k++) begin
                    if (level_q == 6'(k)) seq_d[2*k +: 2] = lfsr_q[1:0];
                end
                level_d = level_q + 6'd1;
                idx_d   = 6'd0;
                timer_d = '0;
                state_d = SHOW_ON;
                // step 0 may be the colour being written this very clock
                led_d   = onehot(step_at(seq_d, 6'd0));
            end
            SHOW_ON: begin
                if (tick) begin
                    if (timer_q == TW'(T_ON - 1)) begin
                        timer_d = '0;
                        led_d   = 4'b0000;
                        state_d = SHOW_OFF;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            SHOW_OFF: begin
                led_d = 4'b0000;
                if (tick) begin
                    if (timer_q == TW'(T_OFF - 1)) begin
                        timer_d = '0;
                        if (idx_q == level_q - 6'd1) begin
                            idx_d   = 6'd0;
                            state_d = WAIT_IN;
                        end else begin
                            idx_d   = idx_q + 6'd1;
                            led_d   = onehot(step_at(seq_q, idx_q + 6'd1));
                            state_d = SHOW_ON;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            WAIT_IN: begin
                led_d = btn;
                if (btn == 4'b0000) begin
                    if (tick) begin
                        if (timer_q == TW'(T_TIMEOUT - 1)) begin
                            timer_d = '0;
                            led_d   = 4'b0000;
                            state_d = LOSE;
                        end else begin
                            timer_d = timer_q + TW'(1);
                        end
                    end
                end else if (btn == onehot(step_at(seq_q, idx_q))) begin
                    // a press in the same cycle as a tick still clears the timer
                    timer_d = '0;
                    if (idx_q == level_q - 6'd1) begin
                        if (level_q == 6'(MAX_LEN)) begin
                            led_d   = 4'b1111;
                            state_d = WIN;
                        end else begin
                            led_d   = 4'b0000;
                            state_d = ADD;
                        end
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end else begin
                    timer_d = '0;
                    led_d   = 4'b0000;
                    state_d = LOSE;
                end
            end
            WIN: begin
                led_d = 4'b1111;
                if (start) begin
                    led_d   = 4'b0000;
                    level_d = 6'd0;
                    state_d = ADD;
                end
            end
            LOSE: begin
                led_d = 4'b0000;
                if (start) begin
                    level_d = 6'd0;
                    state_d = ADD;
                end
            end
            default: begin
                led_d   = 4'b0000;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ADD) || (state_d == SHOW_ON) ||
                 (state_d == SHOW_OFF) || (state_d == WAIT_IN);
        win_d  = (state_d == WIN);
        lose_d = (state_d == LOSE);
    end

    always_ff @(posedge CLK) begin
        if (R) begin
            state_q <= IDLE;
            led_q   <= 4'b0000;
            level_q <= 6'd0;
            busy_q  <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            seq_q   <= '0;
            idx_q   <= 6'd0;
            timer_q <= '0;
            lfsr_q  <= SEED;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            level_q <= level_d;
            busy_q  <= busy_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
            seq_q   <= seq_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign led   = led_q;
    assign level = level_q;
    assign busy  = busy_q;
    assign win   = win_q;
    assign lose  = lose_q;

endmodule

// File: tb/tb_genius_seq_ctrl.sv
// Bench for genius_seq_ctrl: a default N=64 instance and an N=4 instance share stimulus;
// both see the same LFSR colours, so the small one wins where the large one keeps going.
module tb_genius_seq_ctrl;

    localparam int          T_ON      = 4;
    localparam int          T_OFF     = 2;
    localparam int          T_TIMEOUT = 16;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic       CLK = 1'b0;
    logic       R = 1'b1, tick = 1'b0, start = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic [3:0] led, led4;
    logic [5:0] level, level4;
    logic       busy, win, lose, busy4, win4, lose4;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_lfsr;
    logic [1:0]  exp_seq [0:31];

    genius_seq_ctrl dut (
        .CLK(CLK), .R(R), .tick(tick), .start(start), .btn(btn),
        .led(led), .level(level), .busy(busy), .win(win), .lose(lose)
    );

    genius_seq_ctrl #(.N(4)) dut4 (
        .CLK(CLK), .R(R), .tick(tick), .start(start), .btn(btn),
        .led(led4), .level(level4), .busy(busy4), .win(win4), .lose(lose4)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] lfsr_nx(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [3:0] oh(input logic [1:0] c);
        logic [3:0] r;
        r = 4'b0000;
        r[c] = 1'b1;
        return r;
    endfunction

    always @(posedge CLK) begin
        if (R) m_lfsr <= SEED;
        else   m_lfsr <= lfsr_nx(m_lfsr);
    end

    typedef struct {
        logic       r, t, s;
        logic [3:0] b;
        logic [3:0] led;
        logic [5:0] lvl;
        logic       busy, win, lose;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(input logic r, t, s, input logic [3:0] b,
                                input logic [3:0] l, input logic [5:0] lv,
                                input logic bu, w, lo);
        vec_t v;
        v.r = r; v.t = t; v.s = s; v.b = b;
        v.led = l; v.lvl = lv; v.busy = bu; v.win = w; v.lose = lo;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [3:0] l, input logic [5:0] lv,
                           input logic bu, w, lo);
        chk({nm, " led"},   int'(led),   int'(l));
        chk({nm, " level"}, int'(level), int'(lv));
        chk({nm, " busy"},  int'(busy),  int'(bu));
        chk({nm, " win"},   int'(win),   int'(w));
        chk({nm, " lose"},  int'(lose),  int'(lo));
    endtask

    task automatic chk_out4(input string nm, input logic [3:0] l, input logic [5:0] lv,
                            input logic bu, w, lo);
        chk({nm, " led4"},   int'(led4),   int'(l));
        chk({nm, " level4"}, int'(level4), int'(lv));
        chk({nm, " busy4"},  int'(busy4),  int'(bu));
        chk({nm, " win4"},   int'(win4),   int'(w));
        chk({nm, " lose4"},  int'(lose4),  int'(lo));
    endtask

    task automatic cyc(input logic r, t, s, input logic [3:0] b);
        R = r; tick = t; start = s; btn = b;
        @(posedge CLK);
        #1;
        R = 1'b0; tick = 1'b0; start = 1'b0; btn = 4'b0000;
    endtask

    // Called one clock after ADD is entered; plays L steps and ends in WAIT_IN.
    task automatic play(input int L);
        exp_seq[L-1] = m_lfsr[1:0];
        for (int i = 0; i < L; i++) begin
            for (int k = 0; k < T_ON; k++) begin
                cyc(0, 1, 0, 4'b0000);
                chk_out($sformatf("play L%0d s%0d on%0d", L, i, k), oh(exp_seq[i]), 6'(L), 1, 0, 0);
            end
            for (int k = 0; k < T_OFF; k++) begin
                cyc(0, 1, 0, 4'b0000);
                chk_out($sformatf("play L%0d s%0d off%0d", L, i, k), 4'b0000, 6'(L), 1, 0, 0);
            end
        end
        cyc(0, 1, 0, 4'b0000);
        chk_out($sformatf("play L%0d enter wait", L), 4'b0000, 6'(L), 1, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s2;
        logic [1:0]  c0, w, col;
        s2 = lfsr_nx(lfsr_nx(SEED));
        c0 = s2[1:0];

        tbl[0]  = mk(1, 1, 1, 4'b0001, 4'b0000, 6'd0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 4'b0000, 4'b0000, 6'd0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 4'b0000, 4'b0000, 6'd0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 4'b0001, 4'b0000, 6'd0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 1, 4'b0000, 4'b0000, 6'd0, 1, 0, 0);
        tbl[5]  = mk(0, 1, 0, 4'b0000, oh(c0),  6'd1, 1, 0, 0);
        tbl[6]  = mk(0, 1, 0, 4'b0000, oh(c0),  6'd1, 1, 0, 0);
        tbl[7]  = mk(0, 1, 0, 4'b0000, oh(c0),  6'd1, 1, 0, 0);
        tbl[8]  = mk(0, 1, 0, 4'b0000, oh(c0),  6'd1, 1, 0, 0);
        tbl[9]  = mk(0, 1, 0, 4'b0000, 4'b0000, 6'd1, 1, 0, 0);
        tbl[10] = mk(0, 1, 0, 4'b0000, 4'b0000, 6'd1, 1, 0, 0);
        tbl[11] = mk(0, 1, 0, 4'b0000, 4'b0000, 6'd1, 1, 0, 0);

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].r, tbl[i].t, tbl[i].s, tbl[i].b);
            chk_out($sformatf("vec%0d", i), tbl[i].led, tbl[i].lvl,
                    tbl[i].busy, tbl[i].win, tbl[i].lose);
        end
        exp_seq[0] = c0;

        // round 1: correct press together with a tick
        cyc(0, 1, 0, oh(exp_seq[0]));
        chk_out("r1 press", 4'b0000, 6'd1, 1, 0, 0);
        play(2);

        // round 2: the N=4 instance completes its sequence and wins
        cyc(0, 1, 0, oh(exp_seq[0]));
        chk_out("r2 p0 echo", oh(exp_seq[0]), 6'd2, 1, 0, 0);
        cyc(0, 0, 0, oh(exp_seq[1]));
        chk_out("r2 p1", 4'b0000, 6'd2, 1, 0, 0);
        chk_out4("win", 4'b1111, 6'd2, 0, 1, 0);
        play(3);

        // wrong colour
        w = exp_seq[0] + 2'd1;
        cyc(0, 1, 0, oh(w));
        chk_out("wrong", 4'b0000, 6'd3, 0, 0, 1);
        chk_out4("win hold", 4'b1111, 6'd2, 0, 1, 0);
        cyc(0, 1, 0, oh(exp_seq[0]));
        chk_out("lose ign btn", 4'b0000, 6'd3, 0, 0, 1);

        cyc(0, 0, 1, 4'b0000);
        chk_out("restart1", 4'b0000, 6'd0, 1, 0, 0);
        chk_out4("restart1", 4'b0000, 6'd0, 1, 0, 0);
        play(1);

        // multi-bit press
        cyc(0, 0, 0, 4'b0011);
        chk_out("multi", 4'b0000, 6'd1, 0, 0, 1);
        cyc(0, 0, 1, 4'b0000);
        chk_out("restart2", 4'b0000, 6'd0, 1, 0, 0);
        play(1);

        // press on the last tick before timeout beats the timeout
        for (int k = 0; k < T_TIMEOUT - 1; k++) begin
            cyc(0, 1, 0, 4'b0000);
            chk_out($sformatf("save wait%0d", k), 4'b0000, 6'd1, 1, 0, 0);
        end
        cyc(0, 1, 0, oh(exp_seq[0]));
        chk_out("late press", 4'b0000, 6'd1, 1, 0, 0);
        play(2);

        // timeout after exactly T_TIMEOUT ticks
        for (int k = 0; k < T_TIMEOUT - 1; k++) begin
            cyc(0, 1, 0, 4'b0000);
            chk_out($sformatf("to wait%0d", k), 4'b0000, 6'd2, 1, 0, 0);
        end
        cyc(0, 1, 0, 4'b0000);
        chk_out("timeout", 4'b0000, 6'd2, 0, 0, 1);
        chk_out4("timeout", 4'b0000, 6'd2, 0, 0, 1);

        // reset during SHOW_ON
        cyc(0, 0, 1, 4'b0000);
        col = m_lfsr[1:0];
        cyc(0, 1, 0, 4'b0000);
        chk_out("show on", oh(col), 6'd1, 1, 0, 0);
        cyc(0, 1, 1, 4'b0000);
        chk_out("start ignored", oh(col), 6'd1, 1, 0, 0);
        cyc(1, 1, 0, 4'b0000);
        chk_out("mid reset", 4'b0000, 6'd0, 0, 0, 0);
        chk_out4("mid reset", 4'b0000, 6'd0, 0, 0, 0);
        cyc(0, 1, 0, 4'b0001);
        chk_out("idle after reset", 4'b0000, 6'd0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
